qos_umbral_fsm: RTL

- Parametrised successor to the fixed 5-FIFO init/idle/active/error controller in the PCIe QoS datapath.
- Sits beside the Main/VC/D FIFO array. Latches and validates per-FIFO HIGH/LOW thresholds ("umbrales") during INIT and broadcasts them.
- Tracks FIFO occupancy and error status and reports the global link state.
- New relative to the previous generation: N-FIFO generalisation, threshold validation, idle debounce, sticky per-FIFO error capture, and an error-clear recovery path that avoids a full reset.

---
 rtl/qos_umbral_fsm_if.sv | 48 ++++
 rtl/qos_umbral_fsm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/qos_umbral_fsm_if.sv
// Purpose: bundles the control, threshold and status signals of the QoS threshold FSM.
// Latency: none; plain wires between the driver and the controller.
// Backpressure: none; every signal is sampled or presented each cycle without handshake.
interface qos_umbral_fsm_if #(
    parameter int NUM_FIFOS = 5,
    parameter int CNT_W     = 4
);

    // Control requests
    logic                         init;
    logic                         err_clear;

    // Threshold configuration, FIFO i at [i*CNT_W +: CNT_W]
    logic [NUM_FIFOS*CNT_W-1:0]   umbral_high_in;
    logic [NUM_FIFOS*CNT_W-1:0]   umbral_low_in;

    // FIFO array status
    logic [NUM_FIFOS-1:0]         fifo_empty;
    logic [NUM_FIFOS-1:0]         fifo_error;

    // Latched thresholds broadcast to the FIFO array
    logic [NUM_FIFOS*CNT_W-1:0]   umbral_high_out;
    logic [NUM_FIFOS*CNT_W-1:0]   umbral_low_out;

    // Link state reporting
    logic [2:0]                   state_out;
    logic                         init_out;
    logic                         idle_out;
    logic                         active_out;
    logic                         error_out;
    logic [NUM_FIFOS-1:0]         error_full;
    logic                         cfg_err;

    // Side that drives requests and FIFO status
    modport master (
        output init, err_clear, umbral_high_in, umbral_low_in, fifo_empty, fifo_error,
        input  umbral_high_out, umbral_low_out, state_out, init_out, idle_out,
               active_out, error_out, error_full, cfg_err
    );

    // Side implemented by the controller
    modport slave (
        input  init, err_clear, umbral_high_in, umbral_low_in, fifo_empty, fifo_error,
        output umbral_high_out, umbral_low_out, state_out, init_out, idle_out,
               active_out, error_out, error_full, cfg_err
    );

endinterface

// File: rtl/qos_umbral_fsm.sv
// Purpose: latches/validates per-FIFO HIGH/LOW thresholds and reports global link state.
// Latency: outputs are Moore, one edge after the inputs that cause a transition.
// Backpressure: none; inputs are sampled every rising edge, no handshake.
module qos_umbral_fsm #(
    parameter int NUM_FIFOS = 5,
    parameter int CNT_W     = 4,
    parameter int IDLE_DLY  = 2     // legal range 1..255
) (
    input  logic          clk,
    input  logic          reset,
    qos_umbral_fsm_if.slave bus
);

    localparam int         TW         = NUM_FIFOS * CNT_W;
    localparam logic [7:0] IDLE_DLY_C = 8'(IDLE_DLY);

    // Encoding is visible on state_out, so the values are fixed.
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           idle_cnt_q;
    logic [7:0]           idle_cnt_d;
    logic [7:0]           idle_cnt_inc;
    logic [TW-1:0]        high_q;
    logic [TW-1:0]        low_q;
    logic                 cfg_err_q;
    logic [NUM_FIFOS-1:0] err_full_q;
    logic [NUM_FIFOS-1:0] err_full_d;
    logic                 any_err;
    logic                 all_empty;
    logic                 bad_cfg;

    // Summaries of the FIFO status vectors and the saturating idle increment.
    always_comb begin
        any_err      = |bus.fifo_error;
        all_empty    = &bus.fifo_empty;
        idle_cnt_inc = (idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1;
    end

    // Threshold check on the values about to be loaded: low must be strictly below high.
    always_comb begin
        bad_cfg = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (bus.umbral_low_in[i*CNT_W +: CNT_W] >= bus.umbral_high_in[i*CNT_W +: CNT_W]) begin
                bad_cfg = 1'b1;
            end
        end
    end

    // Next-state, idle debounce counter and sticky error mask.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = 8'd0;          // cleared outside ACTIVE and on any non-empty sample
        err_full_d = err_full_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                // fifo_error is deliberately ignored while configuring.
                if (!bus.init && !cfg_err_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_err) begin
                    state_d    = ST_ERROR;
                    err_full_d = bus.fifo_error;
                end else if (bus.init) begin
                    state_d = ST_INIT;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_err) begin
                    state_d    = ST_ERROR;
                    err_full_d = bus.fifo_error;
                end else if (bus.init) begin
                    state_d = ST_INIT;
                end else if (all_empty) begin
                    if (idle_cnt_inc >= IDLE_DLY_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_inc;
                    end
                end
            end
            ST_ERROR: begin
                // Recovery only once the error sources have gone quiet; init has no say here.
                if (bus.err_clear && !any_err) begin
                    state_d    = ST_INIT;
                    err_full_d = '0;
                end else begin
                    err_full_d = err_full_q | bus.fifo_error;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State, idle counter and error mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            idle_cnt_q <= 8'd0;
            err_full_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            err_full_q <= err_full_d;
        end
    end

    // Thresholds and their validity flag are only refreshed while in INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_q    <= '0;
            low_q     <= '0;
            cfg_err_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            high_q    <= bus.umbral_high_in;
            low_q     <= bus.umbral_low_in;
            cfg_err_q <= bad_cfg;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus.state_out       = state_q;
        bus.init_out        = (state_q == ST_INIT);
        bus.idle_out        = (state_q == ST_IDLE);
        bus.active_out      = (state_q == ST_ACTIVE);
        bus.error_out       = (state_q == ST_ERROR);
        bus.error_full      = err_full_q;
        bus.cfg_err         = cfg_err_q;
        bus.umbral_high_out = high_q;
        bus.umbral_low_out  = low_q;
    end

endmodule
